wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline write-back stream and the out-of-order load-return stream from the data cache miss path. The pipeline stream is absorbed into a 2-entry skid FIFO, the two sources are arbitrated each cycle, and the winner is driven onto a registered write port. A pending-load scoreboard gives decode a per-register hazard mask for loads still in flight.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_port_arbiter_if.sv | 46 ++++
 rtl/wb_skid_fifo.sv | 63 ++++++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and sizes for the register-file write-back arbiter.
//   XLEN     - register value width
//   NREGS    - architectural register count
//   REG_AW   - register address width
//   wb_req_t - one write request {destination register, data}
//   grant_src_t - which source owns the write port
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  // "reg" is a reserved word, so the destination field is reg_addr.
  typedef struct packed {
    logic [REG_AW-1:0] reg_addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    GNT_PIPE = 1'b0,
    GNT_LOAD = 1'b1
  } grant_src_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundle of the write-back arbiter's request, issue,
// register-file and hazard-mask signals.
//   pipe_*         - pipeline write-back request (valid/ready handshake)
//   ld_*           - load-return request (valid/ready handshake)
//   ld_issue_*     - load-miss issue notification for the scoreboard
//   rf_*           - registered register-file write port
//   pending_mask   - per-register outstanding-load mask for decode
// Modports: slave = the arbiter, master = whoever drives the requests.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              pipe_valid;
  logic              pipe_ready;
  logic [REG_AW-1:0] pipe_reg;
  logic [XLEN-1:0]   pipe_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_reg;
  logic [XLEN-1:0]   ld_data;

  logic              ld_issue_valid;
  logic [REG_AW-1:0] ld_issue_reg;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [NREGS-1:0]  pending_mask;

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data,
    input  ld_valid, ld_reg, ld_data,
    input  ld_issue_valid, ld_issue_reg,
    output pipe_ready, ld_ready,
    output rf_we, rf_waddr, rf_wdata, pending_mask
  );

  modport master (
    output pipe_valid, pipe_reg, pipe_data,
    output ld_valid, ld_reg, ld_data,
    output ld_issue_valid, ld_issue_reg,
    input  pipe_ready, ld_ready,
    input  rf_we, rf_waddr, rf_wdata, pending_mask
  );

endinterface

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: 2-entry FIFO of write requests absorbing the pipeline stream.
//   clk, reset - clock, synchronous active-high flush
//   push, push_req - enqueue a request (ignored when full)
//   pop            - dequeue the head (ignored when empty)
//   head           - current oldest entry (valid when count != 0)
//   count          - number of stored entries, 0..2
// A full FIFO refuses a push even if it pops in the same cycle, so the
// caller's ready can be derived from the registered count alone.
module wb_skid_fifo
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  wb_req_t    push_req,
  input  logic       pop,
  output wb_req_t    head,
  output logic [1:0] count
);

  wb_req_t    mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       push_ok;
  logic       pop_ok;

  assign push_ok = push && (count_reg != 2'd2);
  assign pop_ok  = pop && (count_reg != 2'd0);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// pipeline write-back stream (via a 2-entry skid FIFO) and the load-return
// stream, and keeps a pending-load scoreboard for decode.
//   clk, reset - clock, synchronous active-high reset
//   bus        - wb_port_arbiter_if.slave: pipe_*, ld_*, ld_issue_*,
//                rf_we/rf_waddr/rf_wdata, pending_mask
// Build option: define WB_RR_EN for round-robin on ties; otherwise the
// load return always wins and the pipe stream may stall indefinitely.
module wb_port_arbiter
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);

  wb_req_t          pipe_req;
  wb_req_t          fifo_head;
  logic [1:0]       fifo_count;
  logic             fifo_nonempty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             pipe_ready;
  logic             grant_load;
  logic             grant_pipe;
  logic             load_wins_tie;

  logic             rf_we_reg;
  logic [REG_AW-1:0] rf_waddr_reg;
  logic [XLEN-1:0]  rf_wdata_reg;
  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;

  // ---------------------------------------------------------------- FIFO
  assign pipe_req.reg_addr = bus.pipe_reg;
  assign pipe_req.data     = bus.pipe_data;

  // Ready depends only on the registered count, never on this cycle's pop.
  assign pipe_ready = !reset && (fifo_count != 2'd2);
  assign fifo_push  = bus.pipe_valid && pipe_ready;
  assign fifo_pop   = grant_pipe;
  assign fifo_nonempty = (fifo_count != 2'd0);

  wb_skid_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_req (pipe_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  // ----------------------------------------------------------- arbitration
`ifdef WB_RR_EN
  grant_src_t last_grant_reg;
  grant_src_t last_grant_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= GNT_LOAD;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // Only contested cycles move the round-robin pointer.
  always_comb begin
    last_grant_next = last_grant_reg;
    if (fifo_nonempty && bus.ld_valid) begin
      last_grant_next = grant_load ? GNT_LOAD : GNT_PIPE;
    end
  end

  assign load_wins_tie = (last_grant_reg == GNT_PIPE);
`else
  assign load_wins_tie = 1'b1;
`endif

  assign grant_load = !reset && bus.ld_valid && (!fifo_nonempty || load_wins_tie);
  assign grant_pipe = !reset && fifo_nonempty && !grant_load;

  // ------------------------------------------------------ write port regs
  // x0 requests still complete their handshake but never raise rf_we.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else if (grant_load) begin
      rf_we_reg    <= (bus.ld_reg != '0);
      rf_waddr_reg <= bus.ld_reg;
      rf_wdata_reg <= bus.ld_data;
    end else if (grant_pipe) begin
      rf_we_reg    <= (fifo_head.reg_addr != '0);
      rf_waddr_reg <= fifo_head.reg_addr;
      rf_wdata_reg <= fifo_head.data;
    end else begin
      rf_we_reg    <= 1'b0;
    end
  end

  // ------------------------------------------------------------ scoreboard
  // A same-cycle issue and return to one register leaves the bit set:
  // the issue describes a newer load than the one returning.
  genvar gi;
  for (gi = 0; gi < NREGS; gi++) begin : g_pend
    if (gi == 0) begin : g_x0
      assign pending_next[gi] = 1'b0;
    end else begin : g_xn
      logic set_hit;
      logic clr_hit;
      assign set_hit = bus.ld_issue_valid && (bus.ld_issue_reg == REG_AW'(gi));
      assign clr_hit = grant_load && (bus.ld_reg == REG_AW'(gi));
      assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.pipe_ready   = pipe_ready;
  assign bus.ld_ready     = grant_load;
  assign bus.rf_we        = rf_we_reg;
  assign bus.rf_waddr     = rf_waddr_reg;
  assign bus.rf_wdata     = rf_wdata_reg;
  assign bus.pending_mask = pending_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed steps followed by random traffic, all checked
// against a queue-based reference model of the write-back arbiter.
// Honours WB_RR_EN the same way the design does.
module tb_wb_port_arbiter;
  import wb_pkg::*;

`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;

  wb_port_arbiter_if bus_if ();

  wb_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Stimulus state (a held request keeps reg/data until accepted).
  logic              p_valid, l_valid, i_valid;
  logic [REG_AW-1:0] p_reg, l_reg, i_reg;
  logic [XLEN-1:0]   p_data, l_data;
  logic              p_acc, l_acc;

  // Reference model state.
  wb_req_t           fq[$];
  grant_src_t        m_last;
  logic              m_we;
  logic [REG_AW-1:0] m_waddr;
  logic [XLEN-1:0]   m_wdata;
  logic [NREGS-1:0]  m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus_if.pipe_valid     = p_valid;
    bus_if.pipe_reg       = p_reg;
    bus_if.pipe_data      = p_data;
    bus_if.ld_valid       = l_valid;
    bus_if.ld_reg         = l_reg;
    bus_if.ld_data        = l_data;
    bus_if.ld_issue_valid = i_valid;
    bus_if.ld_issue_reg   = i_reg;
  endtask

  // One clock: check handshake outputs mid-cycle, advance the model,
  // then check the registered outputs just after the edge.
  task automatic cycle();
    logic    exp_pr, exp_lr;
    wb_req_t r;
    wb_req_t nr;
    drive();
    #2;
    if (reset) begin
      exp_pr = 1'b0;
      exp_lr = 1'b0;
    end else begin
      exp_pr = (fq.size() < 2);
      if (l_valid && fq.size() != 0) begin
        // Contested: with round-robin the source that did not win last time.
        exp_lr = RR ? (m_last == GNT_PIPE) : 1'b1;
        m_last = exp_lr ? GNT_LOAD : GNT_PIPE;
      end else begin
        exp_lr = l_valid;
      end
    end
    chk("pipe_ready", 32'(bus_if.pipe_ready), 32'(exp_pr));
    chk("ld_ready", 32'(bus_if.ld_ready), 32'(exp_lr));

    p_acc = p_valid && exp_pr;
    l_acc = l_valid && exp_lr;
    if (reset) begin
      fq.delete();
      m_last  = GNT_LOAD;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_pend  = '0;
    end else begin
      if (l_acc) begin
        m_we    = (l_reg != 0);
        m_waddr = l_reg;
        m_wdata = l_data;
        m_pend[l_reg] = 1'b0;
      end else if (fq.size() != 0) begin
        r = fq.pop_front();
        m_we    = (r.reg_addr != 0);
        m_waddr = r.reg_addr;
        m_wdata = r.data;
      end else begin
        m_we = 1'b0;
      end
      if (p_acc) begin
        nr.reg_addr = p_reg;
        nr.data     = p_data;
        fq.push_back(nr);
      end
      if (i_valid && i_reg != 0) m_pend[i_reg] = 1'b1;
    end

    @(posedge clk);
    #1;
    chk("rf_we", 32'(bus_if.rf_we), 32'(m_we));
    chk("rf_waddr", 32'(bus_if.rf_waddr), 32'(m_waddr));
    chk("rf_wdata", bus_if.rf_wdata, m_wdata);
    chk("pending_mask", bus_if.pending_mask, m_pend);
    // A held source that transferred presents its next request.
    if (p_acc) p_data = p_data + 1;
    if (l_acc) l_data = l_data + 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    p_valid = 0; p_reg = '0; p_data = '0;
    l_valid = 0; l_reg = '0; l_data = '0;
    i_valid = 0; i_reg = '0;
    p_acc = 0; l_acc = 0;
    m_last = GNT_LOAD; m_we = 0; m_waddr = '0; m_wdata = '0; m_pend = '0;

    // Reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Pipe write x5 = 0x11: visible on the write port two edges later
    p_valid = 1; p_reg = 5'd5; p_data = 32'h11;
    cycle();
    p_valid = 0;
    cycle();
    cycle();
    chk("pipe_x5_we", 32'(bus_if.rf_we), 32'd0);
    // (the write landed one cycle earlier; re-run to see the exact edge)
    p_valid = 1; p_reg = 5'd5; p_data = 32'h11;
    cycle();
    p_valid = 0;
    cycle();
    chk("pipe_x5_we_n2", 32'(bus_if.rf_we), 32'd1);
    chk("pipe_x5_addr", 32'(bus_if.rf_waddr), 32'd5);
    chk("pipe_x5_data", bus_if.rf_wdata, 32'h11);

    // Load issue x7, then return x7 = 0xDEAD
    i_valid = 1; i_reg = 5'd7;
    cycle();
    i_valid = 0;
    chk("pend7_set", 32'(bus_if.pending_mask[7]), 32'd1);
    l_valid = 1; l_reg = 5'd7; l_data = 32'hDEAD;
    cycle();
    l_valid = 0;
    chk("ld_x7_we", 32'(bus_if.rf_we), 32'd1);
    chk("ld_x7_addr", 32'(bus_if.rf_waddr), 32'd7);
    chk("ld_x7_data", bus_if.rf_wdata, 32'hDEAD);
    chk("pend7_clr", 32'(bus_if.pending_mask[7]), 32'd0);

    // Contention: pipe and load both streaming
    p_valid = 1; p_reg = 5'd9; p_data = 32'h900;
    l_valid = 1; l_reg = 5'd10; l_data = 32'hA00;
    for (int k = 0; k < 8; k++) cycle();
    l_valid = 0;
    for (int k = 0; k < 3; k++) cycle();
    p_valid = 0;
    for (int k = 0; k < 3; k++) cycle();

    // Pipe write to x0 and load issue to x0
    p_valid = 1; p_reg = 5'd0; p_data = 32'hFFFF;
    i_valid = 1; i_reg = 5'd0;
    cycle();
    p_valid = 0; i_valid = 0;
    cycle();
    chk("x0_no_we", 32'(bus_if.rf_we), 32'd0);
    chk("x0_no_pend", bus_if.pending_mask, 32'd0);

    // Same-cycle issue and return to x3: set wins
    i_valid = 1; i_reg = 5'd3;
    l_valid = 1; l_reg = 5'd3; l_data = 32'h333;
    cycle();
    i_valid = 0; l_valid = 0;
    chk("pend3_setwins", 32'(bus_if.pending_mask[3]), 32'd1);

    // Fill the FIFO under load pressure, then reset mid-operation
    p_valid = 1; p_reg = 5'd12; p_data = 32'hC00;
    l_valid = 1; l_reg = 5'd13; l_data = 32'hD00;
    i_valid = 1; i_reg = 5'd14;
    for (int k = 0; k < 4; k++) cycle();
    i_valid = 0;
    reset = 1'b1;
    cycle();
    chk("rst_mid_we", 32'(bus_if.rf_we), 32'd0);
    chk("rst_mid_pend", bus_if.pending_mask, 32'd0);
    reset = 1'b0;
    l_valid = 0;
    cycle();
    p_valid = 0;
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (p_acc || !p_valid) begin
        p_valid = ($urandom_range(2, 0) != 0);
        p_reg   = 5'($urandom_range(31, 0));
        p_data  = $urandom;
      end
      if (l_acc || !l_valid) begin
        l_valid = ($urandom_range(1, 0) != 0);
        l_reg   = 5'($urandom_range(31, 0));
        l_data  = $urandom;
      end
      i_valid = ($urandom_range(3, 0) == 0);
      i_reg   = 5'($urandom_range(31, 0));
      reset   = ($urandom_range(99, 0) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
